skinny_sbox8_serial_ctrl: RTL
=============================

Name: skinny_sbox8_serial_ctrl

Overview:
Sequencer that applies the masked SKINNY 8-bit S-box to all 16 cells of a two-share 128-bit state. It uses a single instance of skinny_sbox8_para1_non_pipelined. That S-box is non-pipelined, so its share inputs and refresh mask must be held stable for its full latency. This block guarantees that, fetches fresh randomness per cell through a valid/ready handshake, and writes each result back in place. It sits between the round-function state register and the randomness source in the serial masked SKINNY-128-384+ datapath.

Parameters:
NCELLS, 16, number of 8-bit cells processed per S-box layer (state width = 8*NCELLS).
SBOX_LAT, 4, clock cycles the S-box inputs are held before its output is sampled.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start_i  input  1  begin an S-box layer; sampled only in IDLE.
st0_i  input  128  state share 0; captured on start.
st1_i  input  128  state share 1; captured on start.
rnd_i  input  16  fresh refresh mask for one cell.
rnd_valid_i  input  1  rnd_i valid.
rnd_ready_o  output  1  block accepts rnd_i this cycle.
busy_o  output  1  high in every state except IDLE.
done_o  output  1  one-cycle pulse; st*_o hold the final result.
st0_o  output  128  working/result share 0.
st1_o  output  128  working/result share 1.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; cell counter, latency counter, mask register, st0/st1 registers all 0.
  - rnd_ready_o=0, busy_o=0, done_o=0.
  - Reset mid-layer abandons the layer; the next start reloads the state from the inputs.
- FSM states: IDLE, FETCH, EVAL, DONE.
- IDLE:
  - start_i=1 -> capture st0_i/st1_i into the working registers, cell=0, go to FETCH.
  - start_i=0 -> stay in IDLE.
- FETCH:
  - rnd_ready_o=1 in this state only.
  - rnd_valid_i & rnd_ready_o -> latch rnd_i into the mask register, lat=0, go to EVAL.
  - Otherwise stall indefinitely in FETCH; the working state is unchanged.
- EVAL:
  - S-box inputs: si0=st0[7:0], si1=st1[7:0], r=mask register. All three are held constant for the whole state.
  - lat increments each cycle.
  - In the cycle with lat=SBOX_LAT-1, at the closing edge:
    - Both working registers shift right by 8 bits.
    - S-box output bo0 is written into st0[127:120] and bo1 into st1[127:120].
    - cell increments.
    - If cell was NCELLS-1, go to DONE; otherwise go to FETCH.
  - After 16 shifts the cells are back in their original positions.
- DONE: done_o=1 for exactly one cycle, then go to IDLE.
- st*_o always show the working registers. They are guaranteed to be the result from the done_o cycle until the next accepted start.
- Cell order: cell k = bits [8k+7:8k], processed k=0..15.
- Timing with rnd_valid_i held high:
  - start accepted in cycle 0.
  - Cell k FETCH occurs in cycle 1+5k.
  - Last writeback at the end of cycle 80.
  - done_o=1 in cycle 81.
  - Each rnd stall cycle adds one cycle.
- start_i is ignored while busy. A start in the done_o cycle is also ignored; it is accepted one cycle later in IDLE.
- Each accepted rnd word is used for exactly one cell; a mask is never reused.
- The mask register is cleared to 0 when entering DONE.
- The block never modifies shares except by S-box writeback, and never combines share 0 with share 1.

Test Plan:
- Zero state, rnd_valid_i held 1, rnd_i=0: st0_i=st1_i=0, start -> done_o in cycle 81; each byte of st0_o^st1_o = 0x65.
- All-ones unmasked input: st0_i=0xFF..FF, st1_i=0, random rnd_i each cell -> every byte of st0_o^st1_o = 0xFF; shares differ from the rnd=0 run.
- Random state and shares vs. reference model: each byte of st0_o^st1_o = S8(byte of st0_i^st1_i), with the cell ordering preserved.
- rnd stalls: rnd_valid_i low for 3 cycles before cells 0, 7 and 15 -> done_o in cycle 90. S-box inputs remain unchanged during every EVAL cycle (checked by assertion). Result matches the no-stall run.
- start_i held high throughout -> exactly one layer processed per IDLE visit; busy_o stays high from cycle 1 to cycle 81.
- rst asserted in cycle 40, start reapplied -> all outputs 0 immediately on reset; the new layer completes correctly with no residue from the aborted layer.

Source files
------------

// File: rtl/skinny_sbox8_serial_ctrl.sv
// Serial masked SKINNY S8 layer: one two-share S-box instance is walked over all
// cells of the state, with a fresh 16-bit mask fetched per cell.

module skinny_sbox8_para1_non_pipelined (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  i_si0,
   input  logic [7:0]  i_si1,
   input  logic [15:0] i_r,
   output logic [7:0]  o_bo0,
   output logic [7:0]  o_bo1
);
   // One S8 round on two shares: masked x4 ^= NOR(x7,x6) and x0 ^= NOR(x3,x2).
   // NOT is applied to share 0 only; each AND cross term takes its own mask bit.
   function automatic logic [15:0] f_round(input logic [7:0] x0, input logic [7:0] x1,
                                           input logic [3:0] rr);
      logic [7:0] n0, n1;
      logic       t0, t1, u0, u1;
      n0 = ~x0;
      n1 = x1;
      t0 = (n0[7] & n0[6]) ^ ((n0[7] & n1[6]) ^ rr[0]) ^ rr[1];
      t1 = (n1[7] & n1[6]) ^ ((n1[7] & n0[6]) ^ rr[1]) ^ rr[0];
      u0 = (n0[3] & n0[2]) ^ ((n0[3] & n1[2]) ^ rr[2]) ^ rr[3];
      u1 = (n1[3] & n1[2]) ^ ((n1[3] & n0[2]) ^ rr[3]) ^ rr[2];
      return {x1 ^ {3'b000, t1, 3'b000, u1}, x0 ^ {3'b000, t0, 3'b000, u0}};
   endfunction

   function automatic logic [7:0] f_perm(input logic [7:0] x);
      return {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
   endfunction

   function automatic logic [7:0] f_fin(input logic [7:0] x);
      return {x[7:3], x[1], x[2], x[0]};
   endfunction

   logic [3:0][3:0] w_rr;
   logic [2:0][7:0] r_s0, r_s1;
   logic [15:0]     w_rd0, w_rd1, w_rd2, w_rd3;

   for (genvar k = 0; k < 4; k++) begin : g_rr
      assign w_rr[k] = {i_r[2*k+9], i_r[2*k+1], i_r[2*k+8], i_r[2*k]};
   end

   assign w_rd0 = f_round(i_si0,   i_si1,   w_rr[0]);
   assign w_rd1 = f_round(r_s0[0], r_s1[0], w_rr[1]);
   assign w_rd2 = f_round(r_s0[1], r_s1[1], w_rr[2]);
   assign w_rd3 = f_round(r_s0[2], r_s1[2], w_rr[3]);

   // Three registered rounds plus a combinational last round: the output is
   // correct in the fourth cycle of held inputs and mask.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s0 <= '0;
         r_s1 <= '0;
      end else begin
         r_s0[0] <= f_perm(w_rd0[7:0]);
         r_s1[0] <= f_perm(w_rd0[15:8]);
         r_s0[1] <= f_perm(w_rd1[7:0]);
         r_s1[1] <= f_perm(w_rd1[15:8]);
         r_s0[2] <= f_perm(w_rd2[7:0]);
         r_s1[2] <= f_perm(w_rd2[15:8]);
      end
   end

   assign o_bo0 = f_fin(w_rd3[7:0]);
   assign o_bo1 = f_fin(w_rd3[15:8]);
endmodule

module skinny_sbox8_serial_ctrl #(
   parameter int NCELLS   = 16,
   parameter int SBOX_LAT = 4   // must cover the S-box depth (4)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [8*NCELLS-1:0]   st0_i,
   input  logic [8*NCELLS-1:0]   st1_i,
   input  logic [15:0]           rnd_i,
   input  logic                  rnd_valid_i,
   output logic                  rnd_ready_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [8*NCELLS-1:0]   st0_o,
   output logic [8*NCELLS-1:0]   st1_o
);
   localparam int W  = 8 * NCELLS;
   localparam int CW = (NCELLS > 1) ? $clog2(NCELLS) : 1;
   localparam int LW = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_EVAL  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]    r_state;
   logic [CW-1:0] r_cell;
   logic [LW-1:0] r_lat;
   logic [15:0]   r_mask;
   logic [W-1:0]  r_st0, r_st1;
   logic [7:0]    w_si0, w_si1, w_bo0, w_bo1;

   // Cell 0 always sits in the low byte; results enter at the top and the
   // whole state rotates back into place after NCELLS writebacks.
   assign w_si0 = r_st0[7:0];
   assign w_si1 = r_st1[7:0];

   skinny_sbox8_para1_non_pipelined u_sbox (
      .clk   (clk),
      .rst   (rst),
      .i_si0 (w_si0),
      .i_si1 (w_si1),
      .i_r   (r_mask),
      .o_bo0 (w_bo0),
      .o_bo1 (w_bo1)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cell  <= '0;
         r_lat   <= '0;
         r_mask  <= '0;
         r_st0   <= '0;
         r_st1   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_st0   <= st0_i;
                  r_st1   <= st1_i;
                  r_cell  <= '0;
                  r_state <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (rnd_valid_i) begin
                  r_mask  <= rnd_i;
                  r_lat   <= '0;
                  r_state <= S_EVAL;
               end
            end
            S_EVAL: begin
               r_lat <= r_lat + 1'b1;
               if (r_lat == LW'(SBOX_LAT - 1)) begin
                  r_st0  <= {w_bo0, r_st0[W-1:8]};
                  r_st1  <= {w_bo1, r_st1[W-1:8]};
                  r_cell <= r_cell + 1'b1;
                  if (r_cell == CW'(NCELLS - 1)) begin
                     r_mask  <= '0;
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_FETCH;
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rnd_ready_o = (r_state == S_FETCH);
   assign busy_o      = (r_state != S_IDLE);
   assign done_o      = (r_state == S_DONE);
   assign st0_o       = r_st0;
   assign st1_o       = r_st1;
endmodule
